// File: rtl/fetch_pc_gen_if.sv
// Fetch-group bus between the PC generator and the ICache stage, plus the
// redirect inputs (flush, branch, prediction) that steer the generator.
// master = the PC generator, slave = the environment / consumer side.
interface fetch_pc_gen_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_WIDTH = 2
);
  logic                   flush_i;
  logic [ADDR_WIDTH-1:0]  flush_pc_i;
  logic                   branch_i;
  logic [ADDR_WIDTH-1:0]  branch_target_i;
  logic                   predict_i;
  logic [ADDR_WIDTH-1:0]  predict_target_i;
  logic                   fetch_ready_i;
  logic [ADDR_WIDTH-1:0]  pc_o;
  logic                   valid_o;
  logic [FETCH_WIDTH-1:0] slot_mask_o;
  logic                   adef_o;

  modport master (
    input  flush_i, flush_pc_i, branch_i, branch_target_i,
           predict_i, predict_target_i, fetch_ready_i,
    output pc_o, valid_o, slot_mask_o, adef_o
  );

  modport slave (
    output flush_i, flush_pc_i, branch_i, branch_target_i,
           predict_i, predict_target_i, fetch_ready_i,
    input  pc_o, valid_o, slot_mask_o, adef_o
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-address generator: emits one aligned fetch group per accepted cycle.
// Latency: redirects appear on pc_o one edge after being sampled.
// Backpressure: with fetch_ready_i=0 the current group is held unchanged.
module fetch_pc_gen #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          FETCH_WIDTH = 2,
  parameter int unsigned RESET_PC    = 32'h1c000000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_pc_gen_if.master bus
);

  localparam int                    GB      = FETCH_WIDTH * 4;
  localparam logic [ADDR_WIDTH-1:0] GB_MASK = ADDR_WIDTH'(GB - 1);
  localparam logic [ADDR_WIDTH-1:0] RST_PC  = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] OFS_MSK = ADDR_WIDTH'(FETCH_WIDTH - 1);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_BOOT  = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0]  pc_d;
  logic                   valid_q;
  logic                   fire;
  logic                   adef;
  logic                   fault;
  logic [ADDR_WIDTH-1:0]  ofs;
  logic [FETCH_WIDTH-1:0] slot_mask;

  // Next-pc selection: flush > fault hold > branch > prediction > sequential.
  always_comb begin
    fire  = valid_q & bus.fetch_ready_i;
    adef  = (pc_q[1:0] != 2'b00);
    // A faulting group is accepted; pc freezes on it unless a flush overrides.
    fault = fire & adef & ~bus.flush_i;
    pc_d  = pc_q;
    if (bus.flush_i) begin
      pc_d = bus.flush_pc_i;
    end else if (fault) begin
      pc_d = pc_q;
    end else if (bus.branch_i && state_q != S_HALT) begin
      pc_d = bus.branch_target_i;
    end else if (fire && bus.predict_i) begin
      pc_d = bus.predict_target_i;
    end else if (fire) begin
      pc_d = (pc_q & ~GB_MASK) + ADDR_WIDTH'(GB);
    end
  end

  // Slot mask: slots from the entry offset upward; slot 0 only on a fault.
  always_comb begin
    ofs       = (pc_q >> 2) & OFS_MSK;
    slot_mask = '0;
    if (valid_q) begin
      if (adef) begin
        slot_mask[0] = 1'b1;
      end else begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          slot_mask[i] = (ADDR_WIDTH'(i) >= ofs);
        end
      end
    end
  end

  // Control FSM with registered pc and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RST_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_RESET: begin
          state_q <= S_BOOT;
          valid_q <= 1'b0;
        end
        S_BOOT: begin
          state_q <= S_RUN;
          valid_q <= 1'b1;
        end
        S_RUN: begin
          if (fault) begin
            state_q <= S_HALT;
            valid_q <= 1'b0;
          end
        end
        S_HALT: begin
          if (bus.flush_i) begin
            state_q <= S_RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_RESET;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_o        = pc_q;
  assign bus.valid_o     = valid_q;
  assign bus.slot_mask_o = slot_mask;
  assign bus.adef_o      = adef;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios followed by random redirects,
// all checked cycle by cycle against a behavioural reference model.
module tb_fetch_pc_gen;

  localparam int          AW = 32;
  localparam int          FW = 2;
  localparam int          GB = FW * 4;
  localparam logic [31:0] RPC = 32'h1c000000;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  fetch_pc_gen_if #(.ADDR_WIDTH(AW), .FETCH_WIDTH(FW)) bus ();

  fetch_pc_gen #(.ADDR_WIDTH(AW), .FETCH_WIDTH(FW), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: current group, validity, halted flag, edges since reset.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_halt;
  int          m_boot;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [FW-1:0] mdl_mask(input logic [31:0] pc, input logic vld);
    logic [FW-1:0] m;
    int            entry;
    m = '0;
    if (!vld) return m;
    if (pc % 4 != 0) return FW'(1);
    entry = int'((pc % GB) / 4);
    for (int i = 0; i < FW; i++) m[i] = (i >= entry);
    return m;
  endfunction

  task automatic mdl_reset();
    m_pc    = RPC;
    m_valid = 1'b0;
    m_halt  = 1'b0;
    m_boot  = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".pc"},    bus.pc_o,                  m_pc);
    chk({tag, ".valid"}, {31'd0, bus.valid_o},      {31'd0, m_valid});
    chk({tag, ".mask"},  {30'd0, bus.slot_mask_o},  {30'd0, mdl_mask(m_pc, m_valid)});
    chk({tag, ".adef"},  {31'd0, bus.adef_o},       {31'd0, (m_pc % 4 != 0)});
  endtask

  // One clock: check at the falling edge, advance the model, step past the rising edge.
  task automatic cyc(input string tag);
    logic [31:0] npc;
    logic        nvalid;
    logic        nhalt;
    logic        fire;
    logic        mis;
    @(negedge clk);
    check_outputs(tag);
    fire   = m_valid && bus.fetch_ready_i;
    mis    = (m_pc % 4 != 0);
    npc    = m_pc;
    nvalid = m_valid;
    nhalt  = m_halt;
    if (bus.flush_i)                      npc = bus.flush_pc_i;
    else if (fire && mis)                 npc = m_pc;
    else if (bus.branch_i && !m_halt)     npc = bus.branch_target_i;
    else if (fire && bus.predict_i)       npc = bus.predict_target_i;
    else if (fire)                        npc = m_pc - (m_pc % GB) + GB;
    if (m_boot < 2) begin
      nvalid = (m_boot == 1);
    end else if (m_halt) begin
      if (bus.flush_i) begin
        nhalt  = 1'b0;
        nvalid = 1'b1;
      end
    end else if (fire && mis && !bus.flush_i) begin
      nhalt  = 1'b1;
      nvalid = 1'b0;
    end
    @(posedge clk);
    if (!rst) begin
      m_pc    = npc;
      m_valid = nvalid;
      m_halt  = nhalt;
      if (m_boot < 2) m_boot++;
    end
    #1;
  endtask

  task automatic idle();
    bus.flush_i          = 1'b0;
    bus.flush_pc_i       = '0;
    bus.branch_i         = 1'b0;
    bus.branch_target_i  = '0;
    bus.predict_i        = 1'b0;
    bus.predict_target_i = '0;
  endtask

  task automatic reset_boot();
    rst = 1'b1;
    mdl_reset();
    repeat (3) cyc("rst");
    rst = 1'b0;
    cyc("boot0");
    cyc("boot1");
  endtask

  logic [31:0] held_pc;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    bus.fetch_ready_i = 1'b1;
    idle();
    mdl_reset();
    #1;
    check_outputs("async_rst");

    // Reset and boot: valid rises two edges after release.
    reset_boot();
    chk("boot_pc",   bus.pc_o,                 32'h1c000000);
    chk("boot_mask", {30'd0, bus.slot_mask_o}, 32'd3);

    // Sequential groups after a branch into the middle of a group.
    bus.branch_i = 1'b1; bus.branch_target_i = 32'h1c000104;
    cyc("br");
    idle();
    chk("seq0_pc",   bus.pc_o,                 32'h1c000104);
    chk("seq0_mask", {30'd0, bus.slot_mask_o}, 32'd2);
    cyc("seq0");
    chk("seq1_pc",   bus.pc_o,                 32'h1c000108);
    chk("seq1_mask", {30'd0, bus.slot_mask_o}, 32'd3);
    cyc("seq1");
    chk("seq2_pc",   bus.pc_o,                 32'h1c000110);

    // Stall then a fired prediction.
    bus.fetch_ready_i = 1'b0;
    held_pc = bus.pc_o;
    repeat (4) cyc("stall");
    chk("stall_pc", bus.pc_o, held_pc);
    bus.fetch_ready_i = 1'b1;
    bus.predict_i = 1'b1; bus.predict_target_i = 32'h1c000200;
    cyc("pred");
    idle();
    chk("pred_pc", bus.pc_o, 32'h1c000200);

    // Redirect collisions.
    bus.flush_i  = 1'b1; bus.flush_pc_i = 32'h1c008000;
    bus.branch_i = 1'b1; bus.branch_target_i = 32'h1c000400;
    bus.predict_i = 1'b1; bus.predict_target_i = 32'h1c000600;
    cyc("coll3");
    chk("coll3_pc", bus.pc_o, 32'h1c008000);
    bus.flush_i = 1'b0;
    cyc("coll2");
    idle();
    chk("coll2_pc", bus.pc_o, 32'h1c000400);

    // Misaligned target: fault, halt, branch ignored, flush recovers.
    bus.fetch_ready_i = 1'b0;
    bus.branch_i = 1'b1; bus.branch_target_i = 32'h1c000102;
    cyc("mis");
    idle();
    chk("mis_adef", {31'd0, bus.adef_o},       32'd1);
    chk("mis_mask", {30'd0, bus.slot_mask_o},  32'd1);
    bus.fetch_ready_i = 1'b1;
    cyc("fault");
    chk("halt_valid", {31'd0, bus.valid_o}, 32'd0);
    bus.branch_i = 1'b1; bus.branch_target_i = 32'h1c000500;
    cyc("halt_br");
    idle();
    chk("halt_pc", bus.pc_o, 32'h1c000102);
    bus.flush_i = 1'b1; bus.flush_pc_i = 32'h1c008000;
    cyc("recover");
    idle();
    chk("rec_pc",    bus.pc_o,                32'h1c008000);
    chk("rec_valid", {31'd0, bus.valid_o},    32'd1);

    // Address wrap, then asynchronous reset mid-cycle.
    bus.branch_i = 1'b1; bus.branch_target_i = 32'hFFFFFFF8;
    cyc("wrap_br");
    idle();
    cyc("wrap");
    chk("wrap_pc", bus.pc_o, 32'h00000000);
    #3 rst = 1'b1;
    #1;
    chk("arst_pc",    bus.pc_o,             32'h1c000000);
    chk("arst_valid", {31'd0, bus.valid_o}, 32'd0);
    mdl_reset();
    cyc("arst");
    reset_boot();

    // Random redirects, predictions and backpressure.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] t;
      bus.fetch_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i       = ($urandom_range(0, 19) == 0);
      bus.branch_i      = ($urandom_range(0, 7) == 0);
      bus.predict_i     = ($urandom_range(0, 2) == 0);
      t = $urandom;
      if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
      bus.flush_pc_i = t;
      t = $urandom;
      if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
      bus.branch_target_i = t;
      t = 32'hFFFFFFE0 + 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 1) == 0) t = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(0, 31) == 0) t[0] = 1'b1;
      bus.predict_target_i = t;
      cyc("rnd");
    end
    idle();
    cyc("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
